// File: rtl/mapa_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mapa_arbiter
// Brief    : Map-RAM arbiter. The renderer has fixed priority; the game uses
//            idle cycles via req/ack. Read data is routed back by owner tag.
// Revision : 1.0 - initial release
// ============================================================================
module mapa_arbiter #(
    parameter int MAP_W      = 40,
    parameter int MAP_H      = 30,
    parameter int ADDR_W     = 11,
    parameter int COLOR_W    = 6,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 800
) (
    input  logic               clk,
    input  logic               reset,
    // renderer
    input  logic               r_req,
    input  logic [9:0]         r_x,
    input  logic [9:0]         r_y,
    output logic               r_valid,
    output logic [COLOR_W-1:0] r_cor,
    // game
    input  logic               g_req,
    input  logic               g_we,
    input  logic [9:0]         g_x,
    input  logic [9:0]         g_y,
    input  logic [COLOR_W-1:0] g_wdata,
    output logic               g_ack,
    output logic               g_err,
    output logic               g_rvalid,
    output logic [COLOR_W-1:0] g_rdata,
    // RAM
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata,
    // status
    output logic               starve
);

    localparam int          c_cnt_w  = $clog2(STARVE_MAX + 1);
    localparam logic [9:0]  c_map_w  = 10'(MAP_W);
    localparam logic [9:0]  c_map_h  = 10'(MAP_H);
    localparam logic [c_cnt_w-1:0] c_starve = c_cnt_w'(STARVE_MAX);

    logic                 w_gnt_r;
    logic                 w_gnt_g;
    logic [9:0]           w_sel_x;
    logic [9:0]           w_sel_y;
    logic                 w_sel_oor;
    logic [19:0]          w_sel_addr;
    logic                 w_new_vld;
    logic [c_cnt_w-1:0]   w_cnt_nxt;

    logic [MEM_LAT:0]     r_tag_vld;
    logic [MEM_LAT:0]     r_tag_own;   // 1 = game
    logic [MEM_LAT:0]     r_tag_zero;
    logic [c_cnt_w-1:0]   r_wait_cnt;

    // A game request is never re-accepted while its ack is still high.
    assign w_gnt_r    = r_req;
    assign w_gnt_g    = !r_req && g_req && !g_ack;
    assign w_sel_x    = w_gnt_r ? r_x : g_x;
    assign w_sel_y    = w_gnt_r ? r_y : g_y;
    assign w_sel_oor  = (w_sel_x >= c_map_w) || (w_sel_y >= c_map_h);
    assign w_sel_addr = 20'(w_sel_y) * 20'(c_map_w) + 20'(w_sel_x);
    assign w_new_vld  = w_gnt_r || (w_gnt_g && !g_we);

    always_comb begin
        w_cnt_nxt = r_wait_cnt;
        if (w_gnt_g) begin
            w_cnt_nxt = '0;
        end else if (g_req && !g_ack && (r_wait_cnt < c_starve)) begin
            w_cnt_nxt = r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            g_ack      <= 1'b0;
            g_err      <= 1'b0;
            r_valid    <= 1'b0;
            r_cor      <= '0;
            g_rvalid   <= 1'b0;
            g_rdata    <= '0;
            starve     <= 1'b0;
            r_wait_cnt <= '0;
            r_tag_vld  <= '0;
            r_tag_own  <= '0;
            r_tag_zero <= '0;
        end else begin
            mem_en    <= (w_gnt_r || w_gnt_g) && !w_sel_oor;
            mem_we    <= w_gnt_g && g_we && !w_sel_oor;
            mem_addr  <= ADDR_W'(w_sel_addr);
            mem_wdata <= w_gnt_g ? g_wdata : '0;
            g_ack     <= w_gnt_g;
            g_err     <= w_gnt_g && w_sel_oor;

            r_wait_cnt <= w_cnt_nxt;
            starve     <= (w_cnt_nxt >= c_starve);

            // Stage MEM_LAT lines up with the cycle mem_rdata is valid.
            r_tag_vld  <= {r_tag_vld[MEM_LAT-1:0], w_new_vld};
            r_tag_own  <= {r_tag_own[MEM_LAT-1:0], w_gnt_g && !w_gnt_r};
            r_tag_zero <= {r_tag_zero[MEM_LAT-1:0], w_sel_oor};

            r_valid  <= r_tag_vld[MEM_LAT] && !r_tag_own[MEM_LAT];
            g_rvalid <= r_tag_vld[MEM_LAT] &&  r_tag_own[MEM_LAT];
            if (r_tag_vld[MEM_LAT] && !r_tag_own[MEM_LAT]) begin
                r_cor <= r_tag_zero[MEM_LAT] ? '0 : mem_rdata;
            end
            if (r_tag_vld[MEM_LAT] && r_tag_own[MEM_LAT]) begin
                g_rdata <= r_tag_zero[MEM_LAT] ? '0 : mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mapa_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mapa_arbiter
// Brief    : Directed bench for mapa_arbiter at MEM_LAT=1 (a_*) and MEM_LAT=3 (b_*).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mapa_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ram_init;
    logic       r_req, g_req, g_we;
    logic [9:0] r_x, r_y, g_x, g_y;
    logic [5:0] g_wdata;

    logic        a_r_valid, a_g_ack, a_g_err, a_g_rvalid, a_mem_en, a_mem_we, a_starve;
    logic [5:0]  a_r_cor, a_g_rdata, a_mem_wdata, a_mem_rdata;
    logic [10:0] a_mem_addr;
    logic        b_r_valid, b_g_ack, b_g_err, b_g_rvalid, b_mem_en, b_mem_we, b_starve;
    logic [5:0]  b_r_cor, b_g_rdata, b_mem_wdata, b_mem_rdata;
    logic [10:0] b_mem_addr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mapa_arbiter #(.MEM_LAT(1), .STARVE_MAX(16)) u_dut_a (
        .clk(clk), .reset(rst),
        .r_req(r_req), .r_x(r_x), .r_y(r_y), .r_valid(a_r_valid), .r_cor(a_r_cor),
        .g_req(g_req), .g_we(g_we), .g_x(g_x), .g_y(g_y), .g_wdata(g_wdata),
        .g_ack(a_g_ack), .g_err(a_g_err), .g_rvalid(a_g_rvalid), .g_rdata(a_g_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .starve(a_starve)
    );

    mapa_arbiter #(.MEM_LAT(3), .STARVE_MAX(16)) u_dut_b (
        .clk(clk), .reset(rst),
        .r_req(r_req), .r_x(r_x), .r_y(r_y), .r_valid(b_r_valid), .r_cor(b_r_cor),
        .g_req(g_req), .g_we(g_we), .g_x(g_x), .g_y(g_y), .g_wdata(g_wdata),
        .g_ack(b_g_ack), .g_err(b_g_err), .g_rvalid(b_g_rvalid), .g_rdata(b_g_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .starve(b_starve)
    );

    function automatic logic [5:0] pat(input int a);
        return 6'((a * 7 + 3) & 63);
    endfunction

    // RAM models: latency 1 and 3, preloaded with pat() while ram_init is high.
    logic [5:0] ram_a [2048];
    logic [5:0] ram_b [2048];
    logic [5:0] rp_a;
    logic [5:0] rp_b [3];
    assign a_mem_rdata = rp_a;
    assign b_mem_rdata = rp_b[2];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 2048; i++) begin
                ram_a[i] <= pat(i);
                ram_b[i] <= pat(i);
            end
        end else begin
            if (a_mem_en && a_mem_we) ram_a[a_mem_addr] <= a_mem_wdata;
            if (a_mem_en && !a_mem_we) rp_a <= ram_a[a_mem_addr];
            if (b_mem_en && b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
            rp_b[0] <= (b_mem_en && !b_mem_we) ? ram_b[b_mem_addr] : 6'h00;
            rp_b[1] <= rp_b[0];
            rp_b[2] <= rp_b[1];
        end
    end

    logic [35:0] a_all, b_all;
    assign a_all = {a_r_valid, a_r_cor, a_g_ack, a_g_err, a_g_rvalid, a_g_rdata,
                    a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_starve};
    assign b_all = {b_r_valid, b_r_cor, b_g_ack, b_g_err, b_g_rvalid, b_g_rdata,
                    b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_starve};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ram_init = 1'b1;
        r_req = 1'b0; r_x = '0; r_y = '0;
        g_req = 1'b0; g_we = 1'b0; g_x = '0; g_y = '0; g_wdata = '0;
        tick(); tick();
        check_eq("reset_a", 64'(a_all), 64'd0);
        check_eq("reset_b", 64'(b_all), 64'd0);
        rst = 1'b0; ram_init = 1'b0;

        // 1: renderer read (3,2) -> address 83
        r_req = 1'b1; r_x = 10'd3; r_y = 10'd2;
        tick();
        check_eq("t1_mem_en", 64'(a_mem_en), 64'd1);
        check_eq("t1_mem_addr", 64'(a_mem_addr), 64'd83);
        r_req = 1'b0;
        tick();
        check_eq("t1_rvalid_early", 64'(a_r_valid), 64'd0);
        tick();
        check_eq("t1_rvalid", 64'(a_r_valid), 64'd1);
        check_eq("t1_rcor", 64'(a_r_cor), 64'(pat(83)));

        // 2: game write (5,0)=2A, then read it back
        tick();
        g_req = 1'b1; g_we = 1'b1; g_x = 10'd5; g_y = 10'd0; g_wdata = 6'h2A;
        tick();
        check_eq("t2_ack", 64'(a_g_ack), 64'd1);
        check_eq("t2_err", 64'(a_g_err), 64'd0);
        check_eq("t2_mem", 64'({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata}),
                 64'({1'b1, 1'b1, 11'd5, 6'h2A}));
        g_req = 1'b0;
        tick();
        g_req = 1'b1; g_we = 1'b0;
        tick();
        check_eq("t2_rd_ack", 64'(a_g_ack), 64'd1);
        g_req = 1'b0;
        tick();
        check_eq("t2_rvalid_early", 64'(a_g_rvalid), 64'd0);
        tick();
        check_eq("t2_rvalid", 64'(a_g_rvalid), 64'd1);
        check_eq("t2_rdata", 64'(a_g_rdata), 64'h2A);

        // 3: 40 renderer reads of row 1 while a game read of (7,2) waits
        tick();
        r_req = 1'b1; r_x = 10'd0; r_y = 10'd1;
        g_req = 1'b1; g_we = 1'b0; g_x = 10'd7; g_y = 10'd2;
        for (int k = 1; k <= 44; k++) begin
            tick();
            check_eq("t3_rvalid", 64'(a_r_valid), 64'(k >= 3 && k <= 42));
            if (k >= 3 && k <= 42) check_eq("t3_rcor", 64'(a_r_cor), 64'(pat(40 + k - 3)));
            if (k <= 41) begin
                check_eq("t3_starve", 64'(a_starve), 64'(k >= 16 && k <= 40));
                check_eq("t3_ack", 64'(a_g_ack), 64'(k == 41));
            end
            if (k >= 42) check_eq("t3_grvalid", 64'(a_g_rvalid), 64'(k == 43));
            if (k == 43) check_eq("t3_grdata", 64'(a_g_rdata), 64'(pat(87)));
            if (k < 40) begin
                r_req = 1'b1; r_x = 10'(k);
            end else begin
                r_req = 1'b0;
            end
            if (k == 41) g_req = 1'b0;
        end

        // 4: out-of-range game write, renderer read, game read
        g_req = 1'b1; g_we = 1'b1; g_x = 10'd40; g_y = 10'd0; g_wdata = 6'h3F;
        tick();
        check_eq("t4_w_ackerr", 64'({a_g_ack, a_g_err}), 64'b11);
        check_eq("t4_w_mem_en", 64'(a_mem_en), 64'd0);
        g_req = 1'b0;
        tick();
        r_req = 1'b1; r_x = 10'd0; r_y = 10'd30;
        tick();
        check_eq("t4_r_mem_en", 64'(a_mem_en), 64'd0);
        r_req = 1'b0;
        tick();
        tick();
        check_eq("t4_r_valid_cor", 64'({a_r_valid, a_r_cor}), 64'({1'b1, 6'h00}));
        g_req = 1'b1; g_we = 1'b0; g_x = 10'd0; g_y = 10'd30;
        tick();
        check_eq("t4_g_ackerr", 64'({a_g_ack, a_g_err, a_mem_en}), 64'b110);
        g_req = 1'b0;
        tick();
        tick();
        check_eq("t4_g_rvalid_data", 64'({a_g_rvalid, a_g_rdata}), 64'({1'b1, 6'h00}));

        // 5: interleaved reads on the MEM_LAT=3 instance
        tick();
        r_req = 1'b1; r_x = 10'd1; r_y = 10'd1;
        g_req = 1'b1; g_we = 1'b0; g_x = 10'd2; g_y = 10'd1;
        tick();
        r_req = 1'b0;
        tick();
        check_eq("t5_ack1", 64'(b_g_ack), 64'd1);
        g_req = 1'b0; r_req = 1'b1; r_x = 10'd3;
        tick();
        r_req = 1'b0; g_req = 1'b1; g_x = 10'd4;
        tick();
        check_eq("t5_ack2", 64'(b_g_ack), 64'd1);
        g_req = 1'b0; r_req = 1'b1; r_x = 10'd5;
        for (int s = 5; s <= 9; s++) begin
            tick();
            r_req = 1'b0;
            check_eq("t5_valids", 64'({b_r_valid, b_g_rvalid}), 64'((s % 2 == 1) ? 2'b10 : 2'b01));
            if (s % 2 == 1) check_eq("t5_rcor", 64'(b_r_cor), 64'(pat(36 + s)));
            else            check_eq("t5_grdata", 64'(b_g_rdata), 64'(pat(36 + s)));
        end

        // 6: reset with reads in flight
        tick();
        r_req = 1'b1; r_x = 10'd6; r_y = 10'd1;
        g_req = 1'b1; g_we = 1'b0; g_x = 10'd7; g_y = 10'd1;
        tick();
        r_x = 10'd8;
        tick();
        rst = 1'b1; r_req = 1'b0; g_req = 1'b0;
        #1;
        check_eq("t6_reset_a", 64'(a_all), 64'd0);
        check_eq("t6_reset_b", 64'(b_all), 64'd0);
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("t6_no_stale", 64'({a_r_valid, a_g_rvalid, a_g_ack, b_r_valid, b_g_rvalid, b_g_ack}),
                     64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
